// File: rtl/clk_div_sel.sv
// clk_div_sel: glitch-free programmable clock divider with boundary-aligned channel switching
module clk_div_sel #(
   parameter int NUM_CH  = 4,
   parameter int DIV_W   = 8,
   parameter int RST_SEL = 0,
   parameter int SEL_W   = $clog2(NUM_CH)
) (
   input  logic                    clk_i,
   input  logic                    arst_i,
   input  logic [NUM_CH*DIV_W-1:0] div_cfg_i,
   input  logic                    en_i,
   input  logic [SEL_W-1:0]        sel_i,
   input  logic                    sel_valid_i,
   output logic                    sel_ready_o,
   output logic                    sel_err_o,
   output logic                    done_o,
   output logic [SEL_W-1:0]        active_sel_o,
   output logic                    clk_o
);
   logic [DIV_W-1:0] cfg [NUM_CH];
   logic [DIV_W-1:0] cnt, cur_h, next_h;
   logic [SEL_W-1:0] active_sel, pend_sel, next_sel;
   logic             pend, bnd, accept, sel_ok;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_cfg
      assign cfg[k] = div_cfg_i[k*DIV_W +: DIV_W];
   end

   assign bnd          = cnt == cur_h && !clk_o;
   assign sel_ok       = 32'(sel_i) < NUM_CH;
   assign accept       = sel_valid_i && !pend;
   assign next_sel     = pend ? pend_sel : active_sel;
   assign next_h       = cfg[next_sel];
   assign sel_ready_o  = !pend;
   assign active_sel_o = active_sel;

   // divider, boundary-aligned switch/park, and request slot
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         cnt        <= '0;
         cur_h      <= '0;
         clk_o      <= 1'b0;
         active_sel <= SEL_W'(RST_SEL);
         pend       <= 1'b0;
         pend_sel   <= '0;
         done_o     <= 1'b0;
         sel_err_o  <= 1'b0;
      end else begin
         done_o    <= bnd && pend;
         sel_err_o <= accept && !sel_ok;
         if (bnd) begin
            active_sel <= next_sel;
            cur_h      <= next_h;
            clk_o      <= en_i;
            cnt        <= en_i ? '0 : next_h;
            pend       <= 1'b0;
         end else if (cnt == cur_h) begin
            cnt   <= '0;
            clk_o <= !clk_o;
         end else begin
            cnt <= cnt + 1'b1;
         end
         if (accept && sel_ok) begin
            pend     <= 1'b1;
            pend_sel <= sel_i;
         end
      end
   end
endmodule

// File: tb/tb_clk_div_sel.sv
// tb_clk_div_sel: scoreboard bench for clk_div_sel edges, done and error pulses
module tb_clk_div_sel;
   logic        clk = 0, arst = 0, en = 1;
   logic [31:0] cfg = {8'd0, 8'd3, 8'd2, 8'd1};
   logic [1:0]  sel = 0;
   logic        val = 0;
   logic        ready, err, done, clk_out;
   logic [1:0]  act;
   logic [23:0] cfg3 = {8'd2, 8'd5, 8'd1};
   logic [1:0]  sel3 = 0;
   logic        val3 = 0;
   logic        ready3, err3, done3, clk3;
   logic [1:0]  act3;
   logic        prev = 0;
   int          cyc = 0, compared = 0, mismatched = 0;
   int          rise_q[$], fall_q[$], done_cyc_q[$], done_sel_q[$], err3_q[$];

   clk_div_sel #(.NUM_CH(4), .DIV_W(8), .RST_SEL(0)) dut (
      .clk_i(clk), .arst_i(arst), .div_cfg_i(cfg), .en_i(en), .sel_i(sel),
      .sel_valid_i(val), .sel_ready_o(ready), .sel_err_o(err), .done_o(done),
      .active_sel_o(act), .clk_o(clk_out));

   clk_div_sel #(.NUM_CH(3), .DIV_W(8), .RST_SEL(0)) dut3 (
      .clk_i(clk), .arst_i(arst), .div_cfg_i(cfg3), .en_i(en), .sel_i(sel3),
      .sel_valid_i(val3), .sel_ready_o(ready3), .sel_err_o(err3), .done_o(done3),
      .active_sel_o(act3), .clk_o(clk3));

   always #5 clk = ~clk;

   // edge index since the latest reset release; edge 1 is the first boundary
   always @(posedge clk) cyc <= arst ? 0 : cyc + 1;

   task automatic chk(input string name, input int actual, input int expected);
      compared++;
      if (actual != expected) begin
         mismatched++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", name, actual, expected, cyc);
      end
   endtask

   task automatic wait_edge(input int n);
      int b = 0;
      do begin
         @(posedge clk);
         #2;
         b++;
      end while (cyc != n && b < 200);
      if (cyc != n) chk("wait_timeout", cyc, n);
   endtask

   // monitor: pop expected events as the DUT produces them
   always @(negedge clk) begin
      if (clk_out && !prev) begin
         if (rise_q.size() == 0) chk("rise_extra", cyc, -1);
         else chk("rise_edge", cyc, rise_q.pop_front());
      end
      if (!clk_out && prev) begin
         if (fall_q.size() == 0) chk("fall_extra", cyc, -1);
         else chk("fall_edge", cyc, fall_q.pop_front());
      end
      prev <= clk_out;
      if (done) begin
         if (done_cyc_q.size() == 0) chk("done_extra", cyc, -1);
         else begin
            chk("done_edge", cyc, done_cyc_q.pop_front());
            chk("done_sel", int'(act), done_sel_q.pop_front());
         end
      end
      chk("main_err", int'(err), 0);
      if (err3) begin
         if (err3_q.size() == 0) chk("err3_extra", cyc, -1);
         else chk("err3_edge", cyc, err3_q.pop_front());
      end
      if (cyc >= 1 && cyc <= 37) begin
         chk("u3_clk", int'(clk3), int'(((cyc - 1) % 4) < 2));
         chk("u3_done", int'(done3), 0);
      end
   end

   initial begin
      #1 arst = 1;
      #1;
      chk("rst_clk", int'(clk_out), 0);
      chk("rst_sel", int'(act), 0);
      chk("rst_ready", int'(ready), 1);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      rise_q.push_back(1); rise_q.push_back(5); rise_q.push_back(9);
      fall_q.push_back(3); fall_q.push_back(7);
      err3_q.push_back(7);
      @(posedge clk);
      @(posedge clk);
      #2 arst = 0;
      wait_edge(1);
      chk("e1_sel", int'(act), 0);
      chk("e1_ready", int'(ready), 1);
      wait_edge(6);
      sel3 = 2'd3; val3 = 1;
      wait_edge(7);
      val3 = 0;
      chk("inv_ready", int'(ready3), 1);
      chk("inv_sel", int'(act3), 0);
      wait_edge(8);
      chk("inv_ready2", int'(ready3), 1);
      chk("inv_sel2", int'(act3), 0);
      wait_edge(9);
      sel = 2'd1; val = 1;
      fall_q.push_back(11); rise_q.push_back(13);
      fall_q.push_back(16); rise_q.push_back(19); fall_q.push_back(22); rise_q.push_back(25);
      done_cyc_q.push_back(13); done_sel_q.push_back(1);
      wait_edge(10);
      val = 0;
      chk("sw_ready", int'(ready), 0);
      wait_edge(13);
      chk("sw_sel", int'(act), 1);
      wait_edge(14);
      chk("sw_ready_back", int'(ready), 1);
      wait_edge(20);
      sel = 2'd2; val = 1;
      fall_q.push_back(29); rise_q.push_back(33);
      done_cyc_q.push_back(25); done_sel_q.push_back(2);
      wait_edge(21);
      sel = 2'd3;
      fall_q.push_back(34); rise_q.push_back(35); fall_q.push_back(36);
      rise_q.push_back(37); fall_q.push_back(38);
      done_cyc_q.push_back(33); done_sel_q.push_back(3);
      wait_edge(24);
      chk("b2b_held", int'(ready), 0);
      wait_edge(25);
      chk("b2b_free", int'(ready), 1);
      chk("b2b_sel", int'(act), 2);
      wait_edge(26);
      val = 0;
      chk("b2b_acc", int'(ready), 0);
      wait_edge(37);
      en = 0; sel = 2'd2; val = 1;
      done_cyc_q.push_back(39); done_sel_q.push_back(2);
      wait_edge(38);
      val = 0;
      wait_edge(39);
      chk("park_sel", int'(act), 2);
      wait_edge(42);
      chk("park_clk", int'(clk_out), 0);
      chk("park_ready", int'(ready), 1);
      wait_edge(44);
      en = 1;
      rise_q.push_back(45);
      wait_edge(45);
      chk("unpark_clk", int'(clk_out), 1);
      sel = 2'd1; val = 1;
      wait_edge(46);
      val = 0;
      chk("rst_pend", int'(ready), 0);
      wait_edge(47);
      fall_q.push_back(47);
      arst = 1;
      #1;
      chk("arst_clk", int'(clk_out), 0);
      chk("arst_sel", int'(act), 0);
      chk("arst_ready", int'(ready), 1);
      rise_q.push_back(1); rise_q.push_back(5); rise_q.push_back(9);
      fall_q.push_back(3); fall_q.push_back(7);
      repeat (3) @(posedge clk);
      #2 arst = 0;
      wait_edge(6);
      chk("post_sel", int'(act), 0);
      chk("post_ready", int'(ready), 1);
      wait_edge(10);
      chk("rise_left", rise_q.size(), 0);
      chk("fall_left", fall_q.size(), 0);
      chk("done_left", done_cyc_q.size(), 0);
      chk("err3_left", err3_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
